reg_wb_arbiter: RTL and testbench

- Shares the integer register file's single write port between three write-back requesters: ALU pipe (req 0), LSU (req 1) and MDU (req 2).
- Grants at most one request per cycle using fixed priority with starvation aging.
- Registers the granted write and drives the register file's wr_en/addr_wr/data_wr.
- Exports a one-cycle pending-write mask so issue logic can see the write in flight.

---
 rtl/reg_wb_arbiter.sv | 85 ++++++++
 tb/tb_reg_wb_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the integer register file's single write port.
// Fixed priority LSU > MDU > ALU with per-requester starvation aging; x0 writes are dropped.
module reg_wb_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 64,
  parameter int AGE_MAX = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req_valid,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_data,
  output logic [2:0]          req_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   addr_wr,
  output logic [DATA_W-1:0]   data_wr,
  output logic [31:0]         pend_mask
);

  localparam logic [2:0] AGE_LIM = 3'(AGE_MAX);

  logic [2:0]        age [3];
  logic [2:0]        elig;
  logic [2:0]        x0;
  logic [2:0]        starved;
  logic [2:0]        grant;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;

  always_comb begin
    elig    = '0;
    x0      = '0;
    starved = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      elig[i]    = req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] != '0);
      x0[i]      = req_valid[i] && (req_addr[i*ADDR_W +: ADDR_W] == '0);
      starved[i] = elig[i] && (age[i] == AGE_LIM);
    end
  end

  // Starvation overrides the fixed order; among starved requesters the lowest index wins.
  always_comb begin
    grant = '0;
    if (starved[0])      grant = 3'b001;
    else if (starved[1]) grant = 3'b010;
    else if (starved[2]) grant = 3'b100;
    else if (elig[1])    grant = 3'b010;
    else if (elig[2])    grant = 3'b100;
    else if (elig[0])    grant = 3'b001;
  end

  always_comb begin
    gaddr = '0;
    gdata = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (grant[i]) begin
        gaddr = req_addr[i*ADDR_W +: ADDR_W];
        gdata = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = rst_n ? (grant | x0) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      addr_wr   <= '0;
      data_wr   <= '0;
      pend_mask <= '0;
      for (int unsigned i = 0; i < 3; i++) age[i] <= '0;
    end else begin
      wr_en     <= |grant;
      addr_wr   <= gaddr;
      data_wr   <= gdata;
      pend_mask <= (|grant) ? (32'd1 << gaddr) : '0;
      // x0 requests are accepted at once, so they clear like a grant.
      for (int unsigned i = 0; i < 3; i++) begin
        if (!elig[i] || grant[i])   age[i] <= '0;
        else if (age[i] != AGE_LIM) age[i] <= age[i] + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed, table-driven bench for reg_wb_arbiter with hand-computed expectations.
module tb_reg_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [2:0]     req_valid = '0;
  logic [3*AW-1:0] req_addr = '0;
  logic [3*DW-1:0] req_data = '0;
  logic [2:0]     req_ready;
  logic           wr_en;
  logic [AW-1:0]  addr_wr;
  logic [DW-1:0]  data_wr;
  logic [31:0]    pend_mask;

  int total = 0;
  int bad   = 0;

  reg_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AGE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wr_en(wr_en), .addr_wr(addr_wr),
    .data_wr(data_wr), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [63:0] d0, d1, d2;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [31:0] pm;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] d2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  function automatic vec_t mk(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [2:0] rdy, input logic we,
                              input logic [4:0] wa, input logic [63:0] wd, input logic [31:0] pm);
    vec_t t;
    t.valid = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.rdy = rdy; t.we = we; t.wa = wa; t.wd = wd; t.pm = pm;
    return t;
  endfunction

  initial begin
    // Single ALU write to x5
    tbl.push_back(mk(3'b001, 5, 0, 0, 64'h1234, 0, 0, 3'b001, 1, 5, 64'h1234, 32'h20));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0));
    // x0 drop alongside an MDU write to x7
    tbl.push_back(mk(3'b101, 0, 0, 7, 64'h99, 0, 64'h77, 3'b101, 1, 7, 64'h77, 32'h80));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0));
    // Back-to-back LSU writes
    tbl.push_back(mk(3'b010, 0, 3, 0, 0, 64'hA, 0, 3'b010, 1, 3, 64'hA, 32'h08));
    tbl.push_back(mk(3'b010, 0, 4, 0, 0, 64'hB, 0, 3'b010, 1, 4, 64'hB, 32'h10));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0));
    // Every request targets x0
    tbl.push_back(mk(3'b111, 0, 0, 0, 1, 2, 3, 3'b111, 0, 0, 0, 32'h0));
    // Same-address conflict on x9: LSU first, MDU later
    tbl.push_back(mk(3'b110, 0, 9, 9, 0, 64'h11, 64'h22, 3'b010, 1, 9, 64'h11, 32'h200));
    tbl.push_back(mk(3'b100, 0, 0, 9, 0, 0, 64'h22, 3'b100, 1, 9, 64'h22, 32'h200));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0));
    // Saturated contention: L L L A M L L A with AGE_MAX=3
    tbl.push_back(mk(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0, 3'b010, 1, 2, 64'hB0, 32'h4));
    tbl.push_back(mk(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0, 3'b010, 1, 2, 64'hB0, 32'h4));
    tbl.push_back(mk(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0, 3'b010, 1, 2, 64'hB0, 32'h4));
    tbl.push_back(mk(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0, 3'b001, 1, 1, 64'hA0, 32'h2));
    tbl.push_back(mk(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0, 3'b100, 1, 3, 64'hC0, 32'h8));
    tbl.push_back(mk(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0, 3'b010, 1, 2, 64'hB0, 32'h4));
    tbl.push_back(mk(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0, 3'b010, 1, 2, 64'hB0, 32'h4));
    tbl.push_back(mk(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0, 3'b001, 1, 1, 64'hA0, 32'h2));
    tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 32'h0));

    // Reset held with every requester valid
    drive(3'b111, 1, 2, 3, 64'hA0, 64'hB0, 64'hC0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_addr", 64'(addr_wr), 64'h0);
    chk("rst_data", data_wr, 64'h0);
    chk("rst_pend", 64'(pend_mask), 64'h0);
    rst_n = 1'b1;
    #1 chk("first_grant_ready", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    chk("first_grant_addr", 64'(addr_wr), 64'h2);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].valid, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      #1 chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_en", i), 64'(wr_en), 64'(tbl[i].we));
      chk($sformatf("v%0d_addr", i), 64'(addr_wr), 64'(tbl[i].wa));
      chk($sformatf("v%0d_data", i), data_wr, tbl[i].wd);
      chk($sformatf("v%0d_pend", i), 64'(pend_mask), 64'(tbl[i].pm));
    end

    // Asynchronous reset while a staged write is visible
    @(negedge clk);
    drive(3'b001, 5, 0, 0, 64'h55, 0, 0);
    @(posedge clk); #1;
    chk("mid_wr_en_before", 64'(wr_en), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wr_en", 64'(wr_en), 64'h0);
    chk("mid_addr", 64'(addr_wr), 64'h0);
    chk("mid_pend", 64'(pend_mask), 64'h0);
    chk("mid_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wr_en", 64'(wr_en), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
